// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clock divider bank.
package clk_div_pkg;

    // Common reset divisors for a 100 MHz system clock.
    localparam int unsigned DEF_DIV_50HZ = 1000000;
    localparam int unsigned DEF_DIV_1KHZ = 50000;

    // Default counter/divisor width; wide enough for DEF_DIV_50HZ.
    localparam int unsigned CNT_W_DEF = 21;

    // Channel-select width, never narrower than one bit.
    function automatic int unsigned ch_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Divisor write port: request from the master, one-cycle ack/err back from the bank.
interface clk_div_bank_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = clk_div_pkg::CNT_W_DEF
) ();
    import clk_div_pkg::*;

    localparam int unsigned CH_W = ch_width(NUM_CH);

    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_div;
    logic             wr_ack;
    logic             wr_err;

    modport master (
        output wr_en,
        output wr_ch,
        output wr_div,
        input  wr_ack,
        input  wr_err
    );

    modport slave (
        input  wr_en,
        input  wr_ch,
        input  wr_div,
        output wr_ack,
        output wr_err
    );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active and pending divisor, tick strobe, slow_clk level.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned DEF_DIV = DEF_DIV_50HZ
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             wr_stb,
    input  logic [CNT_W-1:0] wr_div,
    output logic             tick,
    output logic             slow_clk
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic             tick_q, tick_d;
    logic             slow_q, slow_d;
    logic [CNT_W-1:0] div_m1;
    logic             wrap;

    // div is never zero, so div-1 cannot underflow.
    assign div_m1 = div_q - CNT_W'(1);
    assign wrap   = en && (cnt_q == div_m1);

    // Next-state: count, wrap, and decide when a new divisor may take over.
    always_comb begin
        cnt_d    = cnt_q;
        div_d    = div_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        tick_d   = 1'b0;
        slow_d   = slow_q;

        if (!en) begin
            // Idle channel: nothing to keep aligned, so a new divisor lands at once.
            if (wr_stb) begin
                div_d    = wr_div;
                cnt_d    = '0;
                pend_v_d = 1'b0;
            end else if (pend_v_q) begin
                div_d    = pend_q;
                cnt_d    = '0;
                pend_v_d = 1'b0;
            end
        end else begin
            if (wrap) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                slow_d = ~slow_q;
                if (pend_v_q) begin
                    div_d    = pend_q;
                    pend_v_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            // A write in a wrap cycle must wait for the following wrap.
            if (wr_stb) begin
                pend_d   = wr_div;
                pend_v_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            div_q    <= CNT_W'(DEF_DIV);
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            tick_q   <= 1'b0;
            slow_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            tick_q   <= tick_d;
            slow_q   <= slow_d;
        end
    end

    assign tick     = tick_q;
    assign slow_clk = slow_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent runtime-programmable clock dividers.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned DEF_DIV = DEF_DIV_50HZ
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    clk_div_bank_if.slave     wr,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] slow_clk
);

    localparam int unsigned CH_W = ch_width(NUM_CH);

    logic              wr_ok;
    logic [NUM_CH-1:0] wr_sel;
    logic              ack_q, ack_d;
    logic              err_q, err_d;

    // Write decode: only an existing channel and a nonzero divisor are accepted.
    always_comb begin
        wr_ok  = wr.wr_en && (32'(wr.wr_ch) < NUM_CH) && (wr.wr_div != '0);
        ack_d  = wr_ok;
        err_d  = wr.wr_en && !wr_ok;
        wr_sel = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            wr_sel[i] = wr_ok && (wr.wr_ch == CH_W'(i));
        end
    end

    // Registered one-cycle write response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            err_q <= err_d;
        end
    end

    assign wr.wr_ack = ack_q;
    assign wr.wr_err = err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en[g]),
            .wr_stb   (wr_sel[g]),
            .wr_div   (wr.wr_div),
            .tick     (tick[g]),
            .slow_clk (slow_clk[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: vector table, directed corner sequences, random run.
module tb_clk_div_bank;

    localparam int unsigned NCH = 3;
    localparam int unsigned CW  = 8;
    localparam int unsigned DD  = 4;
    localparam int unsigned CHW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] en = '0;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] slow_clk;

    clk_div_bank_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    clk_div_bank #(
        .NUM_CH  (NCH),
        .CNT_W   (CW),
        .DEF_DIV (DD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .wr       (bus),
        .tick     (tick),
        .slow_clk (slow_clk)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: cycles remaining in the current interval per channel.
    int             m_div[NCH];
    int             m_rem[NCH];
    int             m_pend[NCH];
    bit             m_pv[NCH];
    logic [NCH-1:0] m_tick;
    logic [NCH-1:0] m_slow;
    logic           m_ack;
    logic           m_err;

    typedef struct {
        logic [NCH-1:0] en;
        logic           wr_en;
        logic [CHW-1:0] wr_ch;
        logic [CW-1:0]  wr_div;
        logic [NCH-1:0] tick;
        logic [NCH-1:0] slow;
        logic           ack;
        logic           err;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [NCH-1:0] e, input logic we, input int ch, input int dv);
        en         = e;
        bus.wr_en  = we;
        bus.wr_ch  = CHW'(ch);
        bus.wr_div = CW'(dv);
    endtask

    task automatic model_edge();
        int   ch;
        logic acc;
        logic w;
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                m_div[c]  = DD;
                m_rem[c]  = DD;
                m_pend[c] = 0;
                m_pv[c]   = 1'b0;
            end
            m_tick = '0;
            m_slow = '0;
            m_ack  = 1'b0;
            m_err  = 1'b0;
            return;
        end
        ch    = int'(bus.wr_ch);
        acc   = bus.wr_en && (ch < NCH) && (bus.wr_div != 0);
        m_ack = acc;
        m_err = bus.wr_en && !acc;
        for (int c = 0; c < NCH; c++) begin
            w         = acc && (ch == c);
            m_tick[c] = 1'b0;
            if (!en[c]) begin
                if (w) begin
                    m_div[c] = int'(bus.wr_div);
                    m_rem[c] = m_div[c];
                    m_pv[c]  = 1'b0;
                end else if (m_pv[c]) begin
                    m_div[c] = m_pend[c];
                    m_rem[c] = m_div[c];
                    m_pv[c]  = 1'b0;
                end
            end else begin
                m_rem[c] = m_rem[c] - 1;
                if (m_rem[c] == 0) begin
                    m_tick[c] = 1'b1;
                    m_slow[c] = ~m_slow[c];
                    if (m_pv[c]) begin
                        m_div[c] = m_pend[c];
                        m_pv[c]  = 1'b0;
                    end
                    m_rem[c] = m_div[c];
                end
                if (w) begin
                    m_pend[c] = int'(bus.wr_div);
                    m_pv[c]   = 1'b1;
                end
            end
        end
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model", 32'({bus.wr_ack, bus.wr_err, tick, slow_clk}),
              32'({m_ack, m_err, m_tick, m_slow}));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive('0, 1'b0, 0, 0);
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        bus.wr_en  = 1'b0;
        bus.wr_ch  = '0;
        bus.wr_div = '0;

        // Table: DEF_DIV=4 on channel 0, with rejected and accepted writes mixed in.
        for (int j = 0; j < 12; j++) begin
            tbl[j].en     = 3'b001;
            tbl[j].wr_en  = 1'b0;
            tbl[j].wr_ch  = '0;
            tbl[j].wr_div = '0;
            tbl[j].tick   = (j % 4 == 3) ? 3'b001 : 3'b000;
            tbl[j].slow   = (((j + 1) / 4) % 2 == 1) ? 3'b001 : 3'b000;
            tbl[j].ack    = 1'b0;
            tbl[j].err    = 1'b0;
        end
        tbl[5].wr_en = 1'b1; tbl[5].wr_ch = 2'd3; tbl[5].wr_div = 8'd5; tbl[5].err = 1'b1;
        tbl[6].wr_en = 1'b1; tbl[6].wr_ch = 2'd2; tbl[6].wr_div = 8'd0; tbl[6].err = 1'b1;
        tbl[9].wr_en = 1'b1; tbl[9].wr_ch = 2'd1; tbl[9].wr_div = 8'd7; tbl[9].ack = 1'b1;

        rst_n = 1'b0;
        drive('0, 1'b0, 0, 0);
        step();
        step();
        check("reset_outs", 32'({bus.wr_ack, bus.wr_err, tick, slow_clk}), 32'(0));
        rst_n = 1'b1;
        for (int j = 0; j < 12; j++) begin
            drive(tbl[j].en, tbl[j].wr_en, int'(tbl[j].wr_ch), int'(tbl[j].wr_div));
            step();
            check("tbl_tick", 32'(tick), 32'(tbl[j].tick));
            check("tbl_slow", 32'(slow_clk), 32'(tbl[j].slow));
            check("tbl_resp", 32'({bus.wr_ack, bus.wr_err}), 32'({tbl[j].ack, tbl[j].err}));
        end

        // Pending write on a running channel waits for the current wrap.
        do_reset();
        drive('0, 1'b1, 1, 10);
        step();
        check("s2_ack_idle", 32'(bus.wr_ack), 32'(1));
        for (int j = 0; j < 17; j++) begin
            if (j == 5) drive(3'b010, 1'b1, 1, 3);
            else        drive(3'b010, 1'b0, 0, 0);
            step();
            check("s2_tick", 32'(tick[1]), 32'(j == 9 || j == 12 || j == 15));
            if (j == 5) check("s2_ack", 32'(bus.wr_ack), 32'(1));
        end

        // Last write before the wrap wins.
        do_reset();
        for (int j = 0; j < 10; j++) begin
            if (j == 0)      drive(3'b001, 1'b1, 0, 6);
            else if (j == 1) drive(3'b001, 1'b1, 0, 2);
            else             drive(3'b001, 1'b0, 0, 0);
            step();
            check("s3_tick", 32'(tick[0]), 32'(j == 3 || j == 5 || j == 7 || j == 9));
        end

        // Enable dropped at count 2 of div 5, then resumed.
        do_reset();
        drive('0, 1'b1, 2, 5);
        step();
        for (int j = 0; j < 2; j++) begin
            drive(3'b100, 1'b0, 0, 0);
            step();
        end
        for (int j = 0; j < 7; j++) begin
            drive('0, 1'b0, 0, 0);
            step();
            check("s5_hold_tick", 32'(tick[2]), 32'(0));
            check("s5_hold_slow", 32'(slow_clk[2]), 32'(0));
        end
        for (int j = 0; j < 3; j++) begin
            drive(3'b100, 1'b0, 0, 0);
            step();
            check("s5_resume_tick", 32'(tick[2]), 32'(j == 2));
            check("s5_resume_slow", 32'(slow_clk[2]), 32'(j == 2));
        end

        // Reset mid-interval discards a pending divisor and a same-cycle write.
        do_reset();
        drive(3'b001, 1'b0, 0, 0);
        step();
        step();
        drive(3'b001, 1'b1, 0, 2);
        step();
        rst_n = 1'b0;
        drive(3'b001, 1'b1, 0, 2);
        step();
        check("s6_reset_outs", 32'({bus.wr_ack, bus.wr_err, tick, slow_clk}), 32'(0));
        rst_n = 1'b1;
        for (int j = 0; j < 8; j++) begin
            drive(3'b001, 1'b0, 0, 0);
            step();
            check("s6_tick", 32'(tick[0]), 32'(j == 3 || j == 7));
        end

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            logic [NCH-1:0] e;
            int             dv;
            for (int c = 0; c < NCH; c++) e[c] = ($urandom_range(0, 9) != 0);
            dv = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 40)) :
                                                int'($urandom_range(0, 12));
            drive(e, ($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)), dv);
            rst_n = ($urandom_range(0, 499) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
